// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

    localparam int unsigned W_DEFAULT = 8;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_addsub.sv
// Ripple-carry add/subtract; sub=1 inverts b and injects a carry-in of 1.
module booth_addsub #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum_c
);

    logic carry;
    logic bx;

    always_comb begin
        carry = sub;
        bx    = 1'b0;
        sum_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            bx       = b[i] ^ sub;
            sum_c[i] = a[i] ^ bx ^ carry;
            carry    = (a[i] & bx) | (a[i] & carry) | (bx & carry);
        end
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: signed W x W -> 2W product, one step per cycle.
// Optional early termination is enabled by defining BOOTH_EARLY_TERM_EN.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a_in,
    input  logic [W-1:0]   b_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product
);

    localparam int unsigned AW = W + 1;
    localparam int unsigned CW = $clog2(W + 1);
    localparam int unsigned VW = 2 * W + 2;

    state_t          state_q, state_d;
    logic [AW-1:0]   a_q, m_q;
    logic [W-1:0]    q_q;
    logic            q1_q;
    logic [CW-1:0]   count_q;

    logic            accept, in_ready_d, out_valid_d;
    logic [1:0]      code;
    logic            sub;
    logic [AW-1:0]   sum, a_sel;
    logic signed [VW-1:0] step_vec;
    logic            early;
    logic            last_step;

    assign accept = in_valid && in_ready;

    booth_addsub #(.N(AW)) u_addsub (
        .a     (a_q),
        .b     (m_q),
        .sub   (sub),
        .sum_c (sum)
    );

`ifdef BOOTH_EARLY_TERM_EN
    logic [W:0] mask, window;

    // Remaining multiplier bits plus q_1 uniform: the rest of the steps are pure shifts.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i <= W; i++) begin
            mask[i] = (CW'(i) <= count_q);
        end
        window = {q_q, q1_q} & mask;
        early  = (window == '0) || (window == mask);
    end
`else
    assign early = 1'b0;
`endif

    // One Booth step: recode, add/sub, arithmetic shift of {A,Q,q_1}.
    always_comb begin
        code  = {q_q[0], q1_q};
        sub   = (code == BOOTH_SUB);
        a_sel = ((code == BOOTH_ADD) || (code == BOOTH_SUB)) ? sum : a_q;
        if (early) begin
            step_vec = $signed({a_q, q_q, q1_q}) >>> count_q;
        end else begin
            step_vec = $signed({a_sel, q_q, q1_q}) >>> 1;
        end
        last_step = early || (count_q == CW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)                 state_d = CALC;
            CALC:    if (last_step)              state_d = DONE;
            DONE:    if (out_valid && out_ready) state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // Datapath registers; product is captured only on the step that completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            count_q <= '0;
            product <= '0;
        end else if (state_q == IDLE && accept) begin
            a_q     <= '0;
            q_q     <= b_in;
            q1_q    <= 1'b0;
            m_q     <= {a_in[W-1], a_in};
            count_q <= CW'(W);
        end else if (state_q == CALC) begin
            a_q     <= step_vec[VW-1:W+1];
            q_q     <= step_vec[W:1];
            q1_q    <= step_vec[0];
            count_q <= last_step ? '0 : count_q - CW'(1);
            if (last_step) begin
                product <= step_vec[2*W:1];
            end
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed self-checking bench for booth_seq_mult.
module tb_booth_seq_mult;
    import booth_pkg::*;

    localparam int unsigned W = W_DEFAULT;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_seq_mult #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge after the accept edge.
    task automatic start_op(input int a, input int b);
        check("in_ready_idle", 16'(in_ready), 16'd1);
        a_in     = W'(a);
        b_in     = W'(b);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("out_valid_after_accept", 16'(out_valid), 16'd0);
        check("in_ready_after_accept", 16'(in_ready), 16'd0);
    endtask

    // exp_lat = 0 skips the latency comparison.
    task automatic wait_done(input string tag, input int exp_lat, input logic [15:0] exp_p);
        int k = 0;
        while (!out_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_valid"}, 16'(out_valid), 16'd1);
        if (exp_lat != 0) check({tag, "_latency"}, 16'(k), 16'(exp_lat));
        check({tag, "_product"}, product, exp_p);
    endtask

    task automatic transfer(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 16'(out_valid), 16'd0);
        check({tag, "_ready_rise"}, 16'(in_ready), 16'd1);
    endtask

    initial begin
        logic [15:0] held;
        int          acc_t [2];
        logic [15:0] prods [2];
        int          nacc;
        int          nout;
        int          lat_main;
        int          lat_zero;
        int          lat_ones;
        int          spacing;

`ifdef BOOTH_EARLY_TERM_EN
        lat_main = 0;
        lat_zero = 1;
        lat_ones = 2;
        spacing  = 5;
`else
        lat_main = 8;
        lat_zero = 8;
        lat_ones = 8;
        spacing  = 10;
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 16'(in_ready), 16'd0);
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_product", product, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_release", 16'(in_ready), 16'd1);

        // Basic products
        start_op(3, 5);
        wait_done("p3x5", lat_main, 16'h000F);
        transfer("p3x5");
        start_op(-7, 6);
        wait_done("pm7x6", lat_main, 16'hFFD6);
        transfer("pm7x6");
        start_op(-128, -128);
        wait_done("pm128xm128", lat_main, 16'h4000);
        transfer("pm128xm128");
        start_op(127, -128);
        wait_done("p127xm128", lat_main, 16'hC080);
        transfer("p127xm128");

        // Early-termination vectors (full latency without the feature)
        start_op(5, 0);
        wait_done("p5x0", lat_zero, 16'h0000);
        transfer("p5x0");
        start_op(5, -1);
        wait_done("p5xm1", lat_ones, 16'hFFFB);
        transfer("p5xm1");

        // Backpressure with input churn
        start_op(10, -3);
        wait_done("bp", lat_main, 16'hFFE2);
        held = product;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a_in     = W'(i + 1);
            b_in     = W'(i + 7);
            @(negedge clk);
            check("bp_valid_held", 16'(out_valid), 16'd1);
            check("bp_product_held", product, held);
            check("bp_in_ready_low", 16'(in_ready), 16'd0);
        end
        in_valid = 1'b0;
        transfer("bp");

        // Reset mid-operation
        start_op(9, 9);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 16'(out_valid), 16'd0);
        check("midrst_product", product, 16'h0000);
        check("midrst_in_ready", 16'(in_ready), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready_release", 16'(in_ready), 16'd1);
        check("midrst_no_valid", 16'(out_valid), 16'd0);
        start_op(2, 2);
        wait_done("p2x2", lat_main, 16'h0004);
        transfer("p2x2");

        // Back-to-back with in_valid and out_ready tied high
        nacc      = 0;
        nout      = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && nout < 2; c++) begin
            if (in_ready) begin
                if (nacc < 2) begin
                    acc_t[nacc] = c;
                    a_in = (nacc == 0) ? W'(1) : W'(-1);
                    b_in = (nacc == 0) ? W'(1) : W'(-1);
                    nacc++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid && nout < 2) begin
                prods[nout] = product;
                nout++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_outputs", 16'(nout), 16'd2);
        check("b2b_accepts", 16'(nacc), 16'd2);
        if (nout == 2) begin
            check("b2b_prod0", prods[0], 16'h0001);
            check("b2b_prod1", prods[1], 16'h0001);
        end
        if (nacc == 2) check("b2b_spacing", 16'(acc_t[1] - acc_t[0]), 16'(spacing));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
